// File: rtl/nav_responder_pkg.sv
// Shared navigation definitions: node width, arena limit, controller state encoding.
package nav_responder_pkg;

  localparam int NODE_W       = 5;
  localparam int NODE_MAX_DEF = 29;

  typedef logic [NODE_W-1:0] node_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_ARRIVE = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  // One node step in the given direction, pinned at 0 and at the arena limit.
  function automatic node_t step_node(input node_t cur, input logic up, input node_t lim);
    node_t nxt;
    nxt = cur;
    if (up) begin
      if (cur < lim) nxt = cur + node_t'(1);
    end else begin
      if (cur != '0) nxt = cur - node_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/nav_watchdog.sv
// Cycle counter that flags when too long has passed without a node tick.
module nav_watchdog #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  // Count idle movement cycles; clear wins, and the count parks at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/nav_responder.sv
// Navigation responder: accepts an end-point request, tracks node ticks from the
// line follower until the target is reached, and faults if ticks stop arriving.
module nav_responder
  import nav_responder_pkg::*;
#(
  parameter int NODE_MAX  = NODE_MAX_DEF,
  parameter int HOME_NODE = 0,
  parameter int TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_en,
  input  logic [NODE_W-1:0] EP,
  input  logic              node_tick,
  input  logic              abort,
  output logic              en,
  output logic              done,
  output logic              err,
  output logic              dir,
  output logic [NODE_W-1:0] cur_node
);

  localparam node_t LIM  = node_t'(NODE_MAX);
  localparam node_t HOME = node_t'(HOME_NODE);

  state_t state;
  node_t  target;
  logic   cpu_en_q;
  logic   request;
  logic   arrived;
  logic   wd_clear;
  logic   wd_inc;
  logic   wd_expired;

  // Only the first cycle of the cpu_en strobe counts as a request.
  assign request  = cpu_en & ~cpu_en_q;
  assign arrived  = (cur_node == target);
  // The watchdog runs only while moving and restarts on every tick.
  assign wd_clear = (state != ST_MOVE) | node_tick;
  assign wd_inc   = (state == ST_MOVE) & ~node_tick & ~arrived;

  nav_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  // Remember the previous cpu_en level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_en_q <= 1'b0;
    else        cpu_en_q <= cpu_en;
  end

  // Controller FSM with registered outputs; abort overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      en       <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      dir      <= 1'b0;
      cur_node <= HOME;
      target   <= HOME;
    end else if (abort) begin
      state <= ST_IDLE;
      en    <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (request) begin
            if (EP <= LIM) begin
              target <= EP;
              dir    <= (EP > cur_node);
              en     <= 1'b1;
              state  <= ST_MOVE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_MOVE: begin
          // Arrival is tested against the already-updated position, so a
          // final tick is seen as arrival on the following cycle.
          if (arrived) begin
            en    <= 1'b0;
            done  <= 1'b1;
            state <= ST_ARRIVE;
          end else if (node_tick) begin
            cur_node <= step_node(cur_node, dir, LIM);
          end else if (wd_expired) begin
            err   <= 1'b1;
            state <= ST_FAULT;
          end
        end
        ST_ARRIVE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_FAULT: begin
          en  <= 1'b1;
          err <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          en    <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nav_responder.md
NAV_RESPONDER -- requirements
Module: nav_responder

Interface
REQ-001 The block SHALL have parameter NODE_MAX, default 29, highest valid arena node index.
REQ-002 The block SHALL have parameter HOME_NODE, default 0, node occupied after reset.
REQ-003 The block SHALL have parameter TIMEOUT, default 1000, maximum clk cycles allowed between node_tick pulses while moving.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low; port clk input 1 rising-edge clock.
REQ-005 Port rst_n input 1: asynchronous active-low reset.
REQ-006 Port cpu_en input 1: request strobe, held high 3 cycles by the initiator.
REQ-007 Port EP input 5: requested end-point node, valid while cpu_en is high.
REQ-008 Port node_tick input 1: one-cycle pulse per node passed, from the line follower.
REQ-009 Port abort input 1: cancel any activity.
REQ-010 Port en output 1: busy; low means the end point has been reached or the block is idle.
REQ-011 Port done output 1: one-cycle arrival pulse.
REQ-012 Port err output 1: one-cycle pulse on a rejected request; level while in FAULT.
REQ-013 Port dir output 1: 1 = toward higher node index, 0 = toward lower.
REQ-014 Port cur_node output 5: current node index.

Function
REQ-015 States SHALL be IDLE, MOVE, ARRIVE and FAULT, with all outputs registered.
REQ-016 Request SHALL be the rising edge of cpu_en (cpu_en=1, registered previous value 0), evaluated only in IDLE.
REQ-017 IDLE with request and EP<=NODE_MAX: latch target=EP, dir=(EP>cur_node), en=1 next cycle, go to MOVE, clear watchdog.
REQ-018 IDLE with request and EP>NODE_MAX: err high one cycle, en stays 0, remain IDLE, target unchanged.
REQ-019 Remaining high cycles of cpu_en after the edge, and any request edge outside IDLE, SHALL be ignored.
REQ-020 MOVE with cur_node==target: go to ARRIVE (same-node request gives exactly one busy cycle).
REQ-021 MOVE with node_tick: cur_node +1 if dir=1, else -1; watchdog cleared; no wrap (saturate at 0 and NODE_MAX).
REQ-022 MOVE without node_tick: watchdog +1; at TIMEOUT-1 go to FAULT.
REQ-023 Arrival check SHALL use the updated cur_node: the cycle after the final node_tick enters ARRIVE.
REQ-024 ARRIVE: en=0 and done=1 for one cycle, then IDLE; cur_node is retained as the new start.
REQ-025 FAULT: en=1 and err=1 held; leave only by abort.
REQ-026 abort SHALL take priority over all events: next state IDLE, en=0, err=0, done=0, cur_node retained.
REQ-027 node_tick in IDLE, ARRIVE or FAULT SHALL be ignored.

Reset
REQ-028 On rst_n low, state SHALL be IDLE, with en=0, done=0, err=0, dir=0, cur_node=HOME_NODE, target=HOME_NODE, watchdog=0 and cpu_en history=0.
REQ-029 Reset SHALL take effect mid-MOVE without producing a done pulse.

Structure
REQ-030 State encoding, node width (5) and NODE_MAX SHALL live in the shared package/include shared with bot_states.
REQ-031 The watchdog SHALL be a sub-module nav_watchdog with ports clear, inc and expired, sized from TIMEOUT.

Verification
REQ-032 Reset, then cpu_en high 3 cycles with EP=8 and ticks every 10 cycles -> dir=1, en high, cur_node steps 0..8, done pulse one cycle after the 8th tick, en low.
REQ-033 From node 19, EP=8 -> dir=0, 11 ticks decrement cur_node to 8, done pulses once.
REQ-034 EP=31 -> one-cycle err pulse, en never rises, state remains IDLE.
REQ-035 EP equal to cur_node -> en high exactly one cycle, then done.
REQ-036 EP=29 with no ticks -> FAULT after TIMEOUT cycles, err held high; abort -> en=0 and err=0 next cycle.
REQ-037 A second cpu_en edge mid-MOVE -> ignored, target unchanged; rst_n low mid-MOVE -> cur_node=HOME_NODE with no done pulse.
